// File: rtl/fifo_burst_reader.sv
// Burst read master: pops burst_len words from a FIFO with a registered read port
// and presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] burst_len,
    output logic          busy,
    output logic          done,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_rd_data,
    input  logic          fifo_empty,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] issued_q, issued_d;
    logic [LW-1:0] sent_q, sent_d;
    logic [1:0]    occ_q, occ_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] skid0_q, skid0_d;
    logic [DW-1:0] skid1_q, skid1_d;

    logic pop;
    logic rd_ok;
    logic last_word;

    // Read is allowed only if the skid can still absorb it after this cycle's pop.
    always_comb begin
        pop       = (occ_q != 2'd0) & out_ready;
        last_word = (sent_q == (len_q - LW'(1)));
        rd_ok     = (state_q == S_RUN) && !fifo_empty && (issued_q < len_q) &&
                    ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    end

    assign fifo_rd_en = rd_ok;
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = skid0_q;
    assign out_last   = out_valid & last_word;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q + LW'(rd_ok);
        sent_d     = sent_q + LW'(pop);
        inflight_d = rd_ok;
        occ_d      = occ_q + 2'(inflight_q) - 2'(pop);
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;

        // skid0 is the head; a capture lands behind whatever survives the pop.
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) skid0_d = fifo_rd_data;
                else               skid1_d = fifo_rd_data;
            end
            2'b01: skid0_d = skid1_q;
            2'b11: begin
                if (occ_q == 2'd1) begin
                    skid0_d = fifo_rd_data;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = fifo_rd_data;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = burst_len;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (burst_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (pop && last_word) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a registered-read FIFO model and a stream monitor.
module tb_fifo_burst_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    fifo_burst_reader #(.DW(DW), .LW(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data appears on fifo_rd_data the cycle after an accepted read.
    logic [DW-1:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int rd_cnt = 0;
    int rd_empty_err = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (wp == rp) begin
                rd_empty_err <= rd_empty_err + 1;
            end else begin
                fifo_rd_data <= mem[rp % 64];
                rp           <= rp + 1;
            end
        end
    end

    // Stream monitor: every transferred word and every done pulse.
    logic [DW-1:0] rx [$];
    logic          rx_last [$];
    int            done_cnt = 0;

    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            rx.push_back(out_data);
            rx_last.push_back(out_last);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wp % 64] = d;
        wp++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(done), 32'd1);
        @(negedge clk); #1;
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_rx(input string tag, input int base, input logic [DW-1:0] first, input int n);
        chk({tag, "_count"}, 32'(rx.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < rx.size()) begin
                chk({tag, "_data"}, rx[base + i], first + 32'(i));
                chk({tag, "_last"}, 32'(rx_last[base + i]), 32'(i == n - 1));
            end
        end
    endtask

    int rd_base;
    int rx_base;
    int done_base;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-word burst, latency and throughput
        for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
        rd_base = rd_cnt;
        @(negedge clk);
        start = 1'b1; burst_len = 8'd4; out_ready = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("t1_c1_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("t1_c2_valid", 32'(out_valid), 32'd0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk); #1;
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_data", out_data, 32'h11 + 32'(c - 3));
            chk("t1_last", 32'(out_last), 32'(c == 6));
        end
        @(negedge clk); #1;
        chk("t1_c7_done", 32'(done), 32'd1);
        chk("t1_c7_valid", 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_c8_busy", 32'(busy), 32'd0);
        chk("t1_c8_done", 32'(done), 32'd0);
        chk("t1_rd_pulses", 32'(rd_cnt - rd_base), 32'd4);

        // Zero-length burst
        rd_base = rd_cnt;
        start = 1'b1; burst_len = 8'd0;
        @(negedge clk); #1;
        start = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk); #1;
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_done_after", 32'(done), 32'd0);
        chk("t2_rd_pulses", 32'(rd_cnt - rd_base), 32'd0);

        // Downstream stall: only two words buffered
        for (int i = 0; i < 6; i++) push(32'h21 + 32'(i));
        rd_base = rd_cnt; rx_base = rx.size();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd6; out_ready = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (c == 4 || c == 10) begin
                chk("t3_stall_valid", 32'(out_valid), 32'd1);
                chk("t3_stall_data", out_data, 32'h21);
            end
        end
        chk("t3_stall_reads", 32'(rd_cnt - rd_base), 32'd2);
        out_ready = 1'b1;
        wait_done("t3_done", 40);
        chk_rx("t3", rx_base, 32'h21, 6);
        chk("t3_rd_pulses", 32'(rd_cnt - rd_base), 32'd6);

        // FIFO underflow mid-burst
        push(32'h31); push(32'h32);
        rd_base = rd_cnt; rx_base = rx.size(); done_base = done_cnt;
        @(negedge clk);
        start = 1'b1; burst_len = 8'd5;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (c == 5) begin
                chk("t4_empty", 32'(fifo_empty), 32'd1);
                chk("t4_stall_rd_en", 32'(fifo_rd_en), 32'd0);
                chk("t4_busy", 32'(busy), 32'd1);
            end
        end
        chk("t4_stall_reads", 32'(rd_cnt - rd_base), 32'd2);
        @(negedge clk);
        push(32'h33); push(32'h34); push(32'h35);
        wait_done("t4_done", 40);
        chk_rx("t4", rx_base, 32'h31, 5);
        chk("t4_done_pulses", 32'(done_cnt - done_base), 32'd1);

        // Start during a burst is ignored
        for (int i = 0; i < 3; i++) push(32'h41 + 32'(i));
        rd_base = rd_cnt; rx_base = rx.size(); done_base = done_cnt;
        start = 1'b1; burst_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; burst_len = 8'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done", 40);
        chk_rx("t5", rx_base, 32'h41, 3);
        chk("t5_rd_pulses", 32'(rd_cnt - rd_base), 32'd3);
        chk("t5_done_pulses", 32'(done_cnt - done_base), 32'd1);

        // Reset mid-burst with a full skid
        for (int i = 0; i < 6; i++) push(32'h51 + 32'(i));
        done_base = done_cnt;
        start = 1'b1; burst_len = 8'd5; out_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            start = 1'b0;
        end
        chk("t6_full_valid", 32'(out_valid), 32'd1);
        chk("t6_full_data", out_data, 32'h51);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_no_done", 32'(done_cnt - done_base), 32'd0);
        rd_base = rd_cnt; rx_base = rx.size();
        @(negedge clk);
        start = 1'b1; burst_len = 8'd1; out_ready = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done("t6_done", 20);
        chk_rx("t6", rx_base, 32'h53, 1);
        chk("t6_rd_pulses", 32'(rd_cnt - rd_base), 32'd1);

        chk("fifo_read_when_empty", 32'(rd_empty_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
